// File: rtl/adder_measure_sequencer.sv
// ============================================================================
// Module   : adder_measure_sequencer
// Brief    : Sequences one ring-oscillator delay measurement of the
//            instrumented adder (load, clear, settle, run, sync, capture).
//            Optional macro SEQ_ACCUM_EN: REPEAT runs, saturating sum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_measure_sequencer #(
    parameter int DATA_W        = 32,
    parameter int WIN_W         = 16,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_CYCLES   = 4,
    parameter int REPEAT        = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              active,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_a,
    input  logic [DATA_W-1:0] cfg_b,
    input  logic [DATA_W-1:0] cfg_ext_mask,
    input  logic [WIN_W-1:0]  cfg_window,
    output logic [DATA_W-1:0] adder_a,
    output logic [DATA_W-1:0] adder_b,
    output logic [DATA_W-1:0] adder_ext_mask,
    output logic              adder_osc_en,
    output logic              adder_cnt_clr,
    input  logic [DATA_W-1:0] adder_cnt_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_RUN     = 3'd3,
        S_STOP    = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [WIN_W-1:0] C_CLR_LAST    = WIN_W'(CLR_CYCLES - 1);
    localparam logic [WIN_W-1:0] C_SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
    localparam logic [WIN_W-1:0] C_SYNC_LAST   = WIN_W'(SYNC_CYCLES - 1);

    if (CLR_CYCLES < 1 || SETTLE_CYCLES < 1 || SYNC_CYCLES < 2 || REPEAT < 1) begin : g_bad_params
        $error("adder_measure_sequencer: illegal cycle-count parameter");
    end

    state_t            state_q, state_d;
    logic [WIN_W-1:0]  cnt_q, cnt_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, mask_q, mask_d, result_q, result_d;
    logic              osc_q, osc_d, clr_q, clr_d, busy_q, busy_d, done_q, done_d;
    logic              kill;

`ifdef SEQ_ACCUM_EN
    localparam int RUN_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [RUN_W-1:0] C_RUN_LAST = RUN_W'(REPEAT - 1);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [DATA_W:0]   sum_wide;
    logic [DATA_W-1:0] sum_sat;

    assign sum_wide = {1'b0, acc_q} + {1'b0, adder_cnt_in};
    assign sum_sat  = sum_wide[DATA_W] ? '1 : sum_wide[DATA_W-1:0];
`endif

    assign kill = abort || !active;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        win_d    = win_q;
        a_d      = a_q;
        b_d      = b_q;
        mask_d   = mask_q;
        result_d = result_q;
`ifdef SEQ_ACCUM_EN
        acc_d    = acc_q;
        run_d    = run_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && !kill) begin
                    state_d = S_LOAD;
                    a_d     = cfg_a;
                    b_d     = cfg_b;
                    mask_d  = cfg_ext_mask;
                    win_d   = (cfg_window == '0) ? WIN_W'(1) : cfg_window;
`ifdef SEQ_ACCUM_EN
                    acc_d   = '0;
                    run_d   = '0;
`endif
                end
            end
            S_LOAD:   if (cnt_q == C_CLR_LAST)    begin state_d = S_SETTLE;  cnt_d = '0; end
            S_SETTLE: if (cnt_q == C_SETTLE_LAST) begin state_d = S_RUN;     cnt_d = '0; end
            S_RUN:    if (cnt_q == win_q - 1'b1)  begin state_d = S_STOP;    cnt_d = '0; end
            S_STOP:   if (cnt_q == C_SYNC_LAST)   begin state_d = S_CAPTURE; cnt_d = '0; end
            S_CAPTURE: begin
                cnt_d = '0;
`ifdef SEQ_ACCUM_EN
                if (run_q == C_RUN_LAST) begin
                    result_d = sum_sat;
                    state_d  = S_DONE;
                end else begin
                    acc_d   = sum_sat;
                    run_d   = run_q + 1'b1;
                    state_d = S_LOAD;
                end
`else
                result_d = adder_cnt_in;
                state_d  = S_DONE;
`endif
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Abort/deselect wins over every transition, including a pending capture.
        if (kill) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end

        // Outputs are a registered decode of the current state, cut off at once on kill.
        clr_d  = !kill && (state_q == S_LOAD);
        osc_d  = !kill && (state_q == S_RUN);
        busy_d = !kill && (state_q != S_IDLE);
        done_d = !kill && (state_q == S_DONE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            win_q    <= WIN_W'(1);
            a_q      <= '0;
            b_q      <= '0;
            mask_q   <= '0;
            result_q <= '0;
            osc_q    <= 1'b0;
            clr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_ACCUM_EN
            acc_q    <= '0;
            run_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mask_q   <= mask_d;
            result_q <= result_d;
            osc_q    <= osc_d;
            clr_q    <= clr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SEQ_ACCUM_EN
            acc_q    <= acc_d;
            run_q    <= run_d;
`endif
        end
    end

    assign adder_a        = a_q;
    assign adder_b        = b_q;
    assign adder_ext_mask = mask_q;
    assign adder_osc_en   = osc_q;
    assign adder_cnt_clr  = clr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign result         = result_q;

endmodule

`default_nettype wire

// File: doc/adder_measure_sequencer.md
Name: adder_measure_sequencer

Overview:
Sequences one delay measurement of the instrumented adder.
- Loads operands and the external-bit mask, then clears the adder's oscillation counter.
- Lets the datapath settle, enables the ring oscillator for a programmed window of clock cycles, then stops it.
- Waits for the oscillator-domain counter to quiesce and captures its value as the result.
- Sits between the logic-analyser configuration registers and the instrumented adder inside the wrapped adder project, in the wb_clk_i domain.

Parameters:
DATA_W, 32, operand, mask and count width
WIN_W, 16, width of run-window length
CLR_CYCLES, 2, cycles adder_cnt_clr is held high (>=1)
SETTLE_CYCLES, 4, cycles between counter clear and oscillator enable (>=1)
SYNC_CYCLES, 4, cycles after oscillator disable before capture (>=2)
REPEAT, 4, runs per measurement, only with SEQ_ACCUM_EN (>=1)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
active  in  1  project select; low forces IDLE
start  in  1  measurement request, sampled in IDLE
abort  in  1  cancel current measurement
cfg_a  in  DATA_W  operand A
cfg_b  in  DATA_W  operand B
cfg_ext_mask  in  DATA_W  1 = bit driven externally, 0 = bit in ring
cfg_window  in  WIN_W  oscillator-enable length in cycles
adder_a  out  DATA_W  operand A to adder
adder_b  out  DATA_W  operand B to adder
adder_ext_mask  out  DATA_W  external-bit select to adder
adder_osc_en  out  1  ring oscillator enable
adder_cnt_clr  out  1  oscillation counter clear
adder_cnt_in  in  DATA_W  oscillation counter value (oscillator domain, stable once quiesced)
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse, result valid
result  out  DATA_W  captured count

Behaviour:
- All outputs are registered (Moore).
- Reset values: adder_a, adder_b, adder_ext_mask, result = 0; adder_osc_en, adder_cnt_clr, busy, done = 0; state = IDLE.
- IDLE: start=1, active=1 and abort=0 at an edge → LOAD. At that same edge adder_a, adder_b and adder_ext_mask latch cfg_a, cfg_b and cfg_ext_mask. The window latches max(cfg_window,1).
- LOAD: lasts CLR_CYCLES cycles, adder_cnt_clr=1 → SETTLE.
- SETTLE: lasts SETTLE_CYCLES cycles, all controls low → RUN.
- RUN: lasts W (latched window) cycles, adder_osc_en=1 → STOP.
- STOP: lasts SYNC_CYCLES cycles, adder_osc_en=0 → CAPTURE.
- CAPTURE: lasts 1 cycle. result <= adder_cnt_in at the end of it → DONE.
- DONE: lasts 1 cycle, done=1 → IDLE.
- Latency: done goes high CLR_CYCLES+SETTLE_CYCLES+W+SYNC_CYCLES+2 cycles after the start-sampling edge. With defaults and W=10 this is 22 cycles.
- start while busy: ignored, never queued.
- abort=1 or active=0 at any edge, any state → IDLE next cycle:
  - adder_osc_en and adder_cnt_clr go low;
  - no done pulse;
  - result is unchanged.
- start and abort in the same IDLE cycle: abort wins.
- adder_a, adder_b and adder_ext_mask hold their last values after DONE or abort until the next accepted start.
- Changes to cfg_* during a measurement have no effect.
- The window counter is WIN_W wide. cfg_window=0 is treated as 1; all-ones gives 2^WIN_W-1 cycles with no wrap.
- Reset asserted mid-measurement: immediate return to reset values, including adder_osc_en=0 without waiting for a clock edge.

Optional Feature:
SEQ_ACCUM_EN
- Defined:
  - After CAPTURE, the FSM returns to LOAD until REPEAT runs are complete, so each run clears the counter again.
  - The accumulator is zeroed at start. Each capture adds adder_cnt_in with saturation at all-ones.
  - result is updated only in the final CAPTURE; done pulses once, after the last run.
  - abort discards the partial sum.
- Undefined: single run as above; REPEAT has no effect.

Test Plan:
- Reset with wb_rst_i=1 mid-RUN → adder_osc_en drops asynchronously; all outputs at reset values; busy=0.
- Defaults; cfg_a=5, cfg_b=3, cfg_window=10, adder_cnt_in=123 during CAPTURE; pulse start →
  - adder_a=5, adder_b=3;
  - cnt_clr high exactly 2 cycles, osc_en high exactly 10 cycles;
  - done high 22 cycles after the start edge with result=123, busy low the next cycle.
- cfg_window=0 → osc_en high exactly 1 cycle; done 13 cycles after start.
- abort during RUN with result previously 123 → IDLE next cycle, osc_en=0, no done, result stays 123. A start issued during STOP of a separate run is ignored (single done).
- active=0 during SETTLE → returns to IDLE, no done. start with active=0 → no response.
- With SEQ_ACCUM_EN, REPEAT=4:
  - adder_cnt_in=100 each run → one done, result=400, cnt_clr pulsed 4 times.
  - adder_cnt_in=0xC0000000 each run → result=0xFFFFFFFF (saturated).
